// File: rtl/coin_acceptor_if.sv
// Signal bundle between the coin mechanism / wash controller side and the coin acceptor.
// refund_valid and coin_reject are one-cycle strobes with no back-pressure; refund_amount is 0 unless refund_valid is high.
interface coin_acceptor_if #(
   parameter int CREDIT_W = 4
);
   logic                coin_valid;
   logic [1:0]          coin_value;
   logic                sel_double;
   logic                cancel;
   logic                wash_done;
   logic                coin_in;
   logic                double_wash;
   logic [CREDIT_W-1:0] credit;
   logic                refund_valid;
   logic [CREDIT_W-1:0] refund_amount;
   logic                coin_reject;
   logic [2:0]          state_dbg;

   modport master (
      output coin_valid, coin_value, sel_double, cancel, wash_done,
      input  coin_in, double_wash, credit, refund_valid, refund_amount, coin_reject, state_dbg
   );

   modport slave (
      input  coin_valid, coin_value, sel_double, cancel, wash_done,
      output coin_in, double_wash, credit, refund_valid, refund_amount, coin_reject, state_dbg
   );
endinterface

// File: rtl/coin_acceptor.sv
// Payment front-end for the wash controller: accumulates coin credit, starts single or
// double washes, tracks the wash through wash_done and reports change/cancellations.
module coin_acceptor #(
   parameter int CREDIT_W     = 4,
   parameter int PRICE_SINGLE = 4,
   parameter int PRICE_DOUBLE = 6,
   parameter int ACK_TIMEOUT  = 8
) (
   input  logic            clk,
   input  logic            rst,
   coin_acceptor_if.slave  bus
);
   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_COLLECT = 3'd1;
   localparam logic [2:0] S_START   = 3'd2;
   localparam logic [2:0] S_ACK     = 3'd3;
   localparam logic [2:0] S_RUN     = 3'd4;
   localparam logic [2:0] S_REFUND  = 3'd5;

   localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
   localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(ACK_TIMEOUT - 1);
   localparam logic [CREDIT_W:0] MAX_CREDIT = {1'b0, {CREDIT_W{1'b1}}};
   localparam logic [CREDIT_W:0] P_SINGLE   = (CREDIT_W+1)'(PRICE_SINGLE);
   localparam logic [CREDIT_W:0] P_DOUBLE   = (CREDIT_W+1)'(PRICE_DOUBLE);

   logic [2:0]          state_q, state_d;
   logic [CREDIT_W-1:0] credit_q, credit_d;
   logic [CREDIT_W-1:0] paid_q, paid_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                coin_in_q, coin_in_d;
   logic                double_wash_q, double_wash_d;
   logic                refund_valid_q, refund_valid_d;
   logic [CREDIT_W-1:0] refund_amount_q, refund_amount_d;
   logic                coin_reject_q, coin_reject_d;

   logic [CREDIT_W:0]   coin_units;
   logic [CREDIT_W:0]   sum;
   logic [CREDIT_W:0]   eff;
   logic [CREDIT_W:0]   price;
   logic [CREDIT_W:0]   change;
   logic                accepting;
   logic                coin_ok;

   always_comb begin
      case (bus.coin_value)
         2'b00:   coin_units = (CREDIT_W+1)'(1);
         2'b01:   coin_units = (CREDIT_W+1)'(2);
         2'b10:   coin_units = (CREDIT_W+1)'(5);
         default: coin_units = '0;
      endcase
   end

   // The sum is one bit wider than credit so an overflowing coin can be detected and rejected.
   assign sum       = {1'b0, credit_q} + coin_units;
   assign accepting = (state_q == S_IDLE) || (state_q == S_COLLECT);
   assign coin_ok   = bus.coin_valid && accepting && (bus.coin_value != 2'b11) && (sum <= MAX_CREDIT);
   assign eff       = coin_ok ? sum : {1'b0, credit_q};
   assign price     = bus.sel_double ? P_DOUBLE : P_SINGLE;
   assign change    = eff - price;

   always_comb begin
      state_d         = state_q;
      credit_d        = credit_q;
      paid_d          = paid_q;
      cnt_d           = cnt_q;
      coin_in_d       = 1'b0;
      double_wash_d   = double_wash_q;
      refund_valid_d  = 1'b0;
      refund_amount_d = '0;
      coin_reject_d   = bus.coin_valid && !coin_ok;

      case (state_q)
         S_IDLE, S_COLLECT: begin
            // Cancel beats a price match; the same-cycle coin is still credited first.
            if ((state_q == S_COLLECT) && bus.cancel) begin
               state_d         = S_REFUND;
               refund_valid_d  = 1'b1;
               refund_amount_d = eff[CREDIT_W-1:0];
               credit_d        = '0;
            end else if (eff >= price) begin
               state_d         = S_START;
               coin_in_d       = 1'b1;
               double_wash_d   = bus.sel_double;
               paid_d          = price[CREDIT_W-1:0];
               credit_d        = eff[CREDIT_W-1:0];
               refund_valid_d  = (change != '0);
               refund_amount_d = change[CREDIT_W-1:0];
            end else begin
               credit_d = eff[CREDIT_W-1:0];
               if (coin_ok) state_d = S_COLLECT;
            end
         end
         S_START: begin
            credit_d = '0;
            cnt_d    = '0;
            state_d  = S_ACK;
         end
         S_ACK: begin
            if (!bus.wash_done) begin
               state_d = S_RUN;
            end else if (cnt_q == CNT_LAST) begin
               state_d         = S_IDLE;
               refund_valid_d  = 1'b1;
               refund_amount_d = paid_q;
               double_wash_d   = 1'b0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_RUN: begin
            if (bus.wash_done) begin
               state_d       = S_IDLE;
               double_wash_d = 1'b0;
            end
         end
         S_REFUND: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= S_IDLE;
         credit_q        <= '0;
         paid_q          <= '0;
         cnt_q           <= '0;
         coin_in_q       <= 1'b0;
         double_wash_q   <= 1'b0;
         refund_valid_q  <= 1'b0;
         refund_amount_q <= '0;
         coin_reject_q   <= 1'b0;
      end else begin
         state_q         <= state_d;
         credit_q        <= credit_d;
         paid_q          <= paid_d;
         cnt_q           <= cnt_d;
         coin_in_q       <= coin_in_d;
         double_wash_q   <= double_wash_d;
         refund_valid_q  <= refund_valid_d;
         refund_amount_q <= refund_amount_d;
         coin_reject_q   <= coin_reject_d;
      end
   end

   assign bus.coin_in       = coin_in_q;
   assign bus.double_wash   = double_wash_q;
   assign bus.credit        = credit_q;
   assign bus.refund_valid  = refund_valid_q;
   assign bus.refund_amount = refund_amount_q;
   assign bus.coin_reject   = coin_reject_q;
   assign bus.state_dbg     = state_q;
endmodule
